// File: rtl/avst_packet_fifo_pkg.sv
// avst_pkg: shared beat layout, error-bit indices and width helper for avst_packet_fifo.
package avst_pkg;

  localparam int AVST_DEF_DATA_W   = 32;
  localparam int AVST_DEF_EMPTY_W  = $clog2(AVST_DEF_DATA_W / 8);
  localparam int AVST_DEF_DEPTH    = 512;
  localparam int AVST_DEF_MAX_PKTS = 16;

  localparam int ERR_NO_SOP     = 0;
  localparam int ERR_NESTED_SOP = 1;
  localparam int ERR_OVERSIZE   = 2;
  localparam int ERR_W          = 3;

  typedef struct packed {
    logic                        sop;
    logic                        eop;
    logic [AVST_DEF_EMPTY_W-1:0] empty;
    logic [AVST_DEF_DATA_W-1:0]  data;
  } avst_beat_t;

  // Width of a counter that must hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/avst_packet_fifo_sdp_ram.sv
// avst_sdp_ram: single-clock simple dual-port RAM, registered read port with enable.
module avst_sdp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/avst_packet_fifo.sv
// avst_packet_fifo: Avalon-ST packet buffer with framing checks.
// Define AVST_FIFO_STORE_FWD_EN to hold output until a whole packet is buffered.
module avst_packet_fifo
  import avst_pkg::*;
#(
  parameter int DATA_W   = AVST_DEF_DATA_W,
  parameter int EMPTY_W  = $clog2(DATA_W / 8),
  parameter int DEPTH    = AVST_DEF_DEPTH,
  parameter int MAX_PKTS = AVST_DEF_MAX_PKTS
) (
  input  logic                       clk_clk,
  input  logic                       rst_reset,
  input  logic [DATA_W-1:0]          snk_data,
  input  logic                       snk_valid,
  output logic                       snk_ready,
  input  logic                       snk_startofpacket,
  input  logic                       snk_endofpacket,
  input  logic [EMPTY_W-1:0]         snk_empty,
  output logic [DATA_W-1:0]          src_data,
  output logic                       src_valid,
  input  logic                       src_ready,
  output logic                       src_startofpacket,
  output logic                       src_endofpacket,
  output logic [EMPTY_W-1:0]         src_empty,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [$clog2(MAX_PKTS):0]  pkt_count,
  output logic [ERR_W-1:0]           proto_err,
  input  logic                       err_clear
);

  typedef struct packed {
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  data;
  } beat_t;

  localparam int AW = $clog2(DEPTH);
  localparam int FW = cnt_width(DEPTH);
  localparam int PW = cnt_width(MAX_PKTS);
  localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);

  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic                     ready_en, pkt_open, out_full;
  logic                     accept, discard, store, load, xfer, oversize;
  logic [ERR_W-1:0]         err_ev;
  logic [$bits(beat_t)-1:0] rd_word;
  beat_t                    wr_beat, rd_beat;

  assign accept  = snk_valid && snk_ready;
  assign discard = accept && !pkt_open && !snk_startofpacket;
  assign store   = accept && !discard;
  assign xfer    = src_valid && src_ready;
  // The RAM read register is the output register: refill it whenever the
  // memory part (fill minus the occupied output slot) still holds beats.
  assign load    = (fill_level != FW'(out_full)) && (!out_full || xfer);

  always_comb begin
    wr_beat       = '0;
    wr_beat.sop   = snk_startofpacket;
    wr_beat.eop   = snk_endofpacket;
    wr_beat.empty = snk_endofpacket ? snk_empty : '0;
    wr_beat.data  = snk_data;
  end

  avst_sdp_ram #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk_clk),
    .wr_en   (store),
    .wr_addr (wr_ptr),
    .wr_data (wr_beat),
    .rd_en   (load),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  assign rd_beat           = beat_t'(rd_word);
  assign src_data          = out_full ? rd_beat.data  : '0;
  assign src_startofpacket = out_full && rd_beat.sop;
  assign src_endofpacket   = out_full && rd_beat.eop;
  assign src_empty         = out_full ? rd_beat.empty : '0;

`ifdef AVST_FIFO_STORE_FWD_EN
  localparam logic [PW-1:0] PKT_LIM = PW'(MAX_PKTS);
  logic pc_nz_q, os_drain;

  assign oversize  = (fill_level == FULL_LVL) && (pkt_count == '0);
  // Release waits one extra cycle after pkt_count rises so the first beat
  // appears two cycles after the eop write, but gating drops immediately.
  assign src_valid = out_full && ((pc_nz_q && (pkt_count != '0)) || os_drain);
  assign snk_ready = ready_en && (fill_level < FULL_LVL) && (pkt_count < PKT_LIM);

  always_ff @(posedge clk_clk) begin
    if (rst_reset) begin
      pc_nz_q  <= 1'b0;
      os_drain <= 1'b0;
    end else begin
      pc_nz_q <= (pkt_count != '0);
      if (os_drain && xfer && rd_beat.eop) os_drain <= 1'b0;
      else if (oversize)                   os_drain <= 1'b1;
    end
  end
`else
  assign oversize  = 1'b0;
  assign src_valid = out_full;
  assign snk_ready = ready_en && (fill_level < FULL_LVL);
`endif

  always_comb begin
    err_ev                 = '0;
    err_ev[ERR_NO_SOP]     = discard;
    err_ev[ERR_NESTED_SOP] = store && snk_startofpacket && pkt_open;
    err_ev[ERR_OVERSIZE]   = oversize;
  end

  always_ff @(posedge clk_clk) begin
    if (rst_reset) begin
      ready_en   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_full   <= 1'b0;
      pkt_open   <= 1'b0;
      fill_level <= '0;
      pkt_count  <= '0;
      proto_err  <= '0;
    end else begin
      ready_en <= 1'b1;
      if (store) begin
        wr_ptr   <= wr_ptr + 1'b1;
        pkt_open <= snk_endofpacket ? 1'b0 : (snk_startofpacket || pkt_open);
      end
      if (load) rd_ptr <= rd_ptr + 1'b1;
      if (load)      out_full <= 1'b1;
      else if (xfer) out_full <= 1'b0;
      case ({store, xfer})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
      case ({store && snk_endofpacket, xfer && rd_beat.eop})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
      proto_err <= (err_clear ? '0 : proto_err) | err_ev;
    end
  end

endmodule
